riscv_irq_controller: RTL and testbench

//   Memory-mapped external interrupt controller (mini-PLIC) that arbitrates N_SRC peripheral

---
 rtl/riscv_irq_pkg.sv | 29 ++
 rtl/riscv_irq_gateway.sv | 41 ++++
 rtl/riscv_irq_controller.sv | 171 +++++++++++++++++
 tb/tb_riscv_irq_controller.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_irq_pkg.sv
// Shared definitions for the external interrupt controller:
// register offsets, ID/priority widths and the bus request bundle.
package riscv_irq_pkg;

    localparam int ID_W   = 5;
    localparam int PRIO_W = 3;

    localparam logic [7:0] OFF_PENDING   = 8'h00;
    localparam logic [7:0] OFF_ENABLE    = 8'h04;
    localparam logic [7:0] OFF_THRESH    = 8'h08;
    localparam logic [7:0] OFF_CLAIM     = 8'h0C;
    localparam logic [7:0] OFF_PRIO_BASE = 8'h20;

    typedef logic [ID_W-1:0]   irq_id_t;
    typedef logic [PRIO_W-1:0] irq_prio_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [7:0]  off;
        logic [31:0] wdata;
    } irq_bus_req_t;

    // Word slot of a priority register relative to PRIO_BASE; equals the ID.
    function automatic logic [5:0] prio_slot(input logic [7:0] off);
        return off[7:2] - 6'd8;
    endfunction

endpackage

// File: rtl/riscv_irq_gateway.sv
// Per-source gateway: two-flop synchroniser, level/edge qualification
// and the pending flop. A gateway set beats a same-cycle claim clear.
module riscv_irq_gateway
#(
    parameter logic EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    input  logic i_in_service,
    input  logic i_clr,
    output logic o_pending
);

    logic r_s1;
    logic r_s2;
    logic r_sq;
    logic r_pend;
    logic w_set;

    // Edge sources record a rise even while in service (one-deep);
    // level sources are held off until the handler completes.
    assign w_set = EDGE ? (r_s2 & ~r_sq) : (r_s2 & ~i_in_service);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_sq   <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_s1   <= i_irq;
            r_s2   <= r_s1;
            r_sq   <= r_s2;
            r_pend <= w_set | (r_pend & ~i_clr);
        end
    end

    assign o_pending = r_pend;

endmodule

// File: rtl/riscv_irq_controller.sv
// Memory-mapped external interrupt controller feeding hardware_irq.
// Optional per-ID priority and threshold: define RISCV_IRQ_PRIORITY_EN.
module riscv_irq_controller
    import riscv_irq_pkg::*;
#(
    parameter int               N_SRC     = 8,
    parameter logic [N_SRC-1:0] EDGE_MASK = '0,
    parameter logic [31:0]      BASE_ADDR = 32'h0000c000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [31:0]      bus_addr,
    input  logic             bus_re,
    input  logic             bus_we,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_rvalid,
    output logic             irq_out
);

    logic [N_SRC:1] w_pend;
    logic [N_SRC:1] w_elig;
    logic [N_SRC:1] w_take;
    logic [N_SRC:1] w_done;
    logic [N_SRC:1] r_en;
    logic [N_SRC:1] r_svc;
    irq_id_t        w_best;
    irq_id_t        w_cid;
    irq_bus_req_t   w_req;
    logic           w_hit;
    logic           w_claim;
    logic           w_cmpl;
    logic [31:0]    w_rword;
    logic [5:0]     w_slot;
    logic           w_unused;

    assign w_hit       = bus_addr[31:8] == BASE_ADDR[31:8];
    assign w_req.rd    = bus_re & ~bus_we & w_hit;
    assign w_req.wr    = bus_we & w_hit;
    assign w_req.off   = {bus_addr[7:2], 2'b00};
    assign w_req.wdata = bus_wdata;

    assign w_cid    = w_req.wdata[ID_W-1:0];
    assign w_claim  = w_req.rd & (w_req.off == OFF_CLAIM);
    assign w_cmpl   = w_req.wr & (w_req.off == OFF_CLAIM);
    assign w_slot   = prio_slot(w_req.off);
    assign w_unused = &{1'b0, bus_addr[1:0], bus_wdata};

    for (genvar i = 1; i <= N_SRC; i++) begin : g_gw
        riscv_irq_gateway #(
            .EDGE(EDGE_MASK[i-1])
        ) u_gw (
            .clk          (clk),
            .rst          (rst),
            .i_irq        (src_irq[i-1]),
            .i_in_service (r_svc[i]),
            .i_clr        (w_take[i]),
            .o_pending    (w_pend[i])
        );
    end

`ifdef RISCV_IRQ_PRIORITY_EN
    irq_prio_t r_prio [1:N_SRC];
    irq_prio_t r_thresh;
    irq_prio_t w_bprio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thresh <= '0;
            for (int i = 1; i <= N_SRC; i++) begin
                r_prio[i] <= '0;
            end
        end else begin
            if (w_req.wr && w_req.off == OFF_THRESH) begin
                r_thresh <= w_req.wdata[PRIO_W-1:0];
            end
            for (int i = 1; i <= N_SRC; i++) begin
                if (w_req.wr && w_req.off >= OFF_PRIO_BASE
                    && w_slot == 6'(i)) begin
                    r_prio[i] <= w_req.wdata[PRIO_W-1:0];
                end
            end
        end
    end
`endif

    // Ascending scan with strict compare keeps the lower ID on ties.
    always_comb begin
        w_elig = '0;
        w_best = '0;
`ifdef RISCV_IRQ_PRIORITY_EN
        w_bprio = '0;
`endif
        for (int i = 1; i <= N_SRC; i++) begin
            w_elig[i] = w_pend[i] & r_en[i] & ~r_svc[i];
`ifdef RISCV_IRQ_PRIORITY_EN
            w_elig[i] = w_elig[i] & (r_prio[i] > r_thresh);
            if (w_elig[i] && (w_best == '0 || r_prio[i] > w_bprio)) begin
                w_best  = irq_id_t'(i);
                w_bprio = r_prio[i];
            end
`else
            if (w_elig[i] && w_best == '0) begin
                w_best = irq_id_t'(i);
            end
`endif
        end
    end

    always_comb begin
        w_take = '0;
        w_done = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            w_take[i] = w_claim & (w_best == irq_id_t'(i));
            w_done[i] = w_cmpl & (w_cid == irq_id_t'(i)) & r_svc[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en  <= '0;
            r_svc <= '0;
        end else begin
            if (w_req.wr && w_req.off == OFF_ENABLE) begin
                r_en <= w_req.wdata[N_SRC:1];
            end
            r_svc <= (r_svc | w_take) & ~w_done;
        end
    end

    always_comb begin
        w_rword = '0;
        unique case (w_req.off)
            OFF_PENDING: w_rword = 32'({w_pend, 1'b0});
            OFF_ENABLE:  w_rword = 32'({r_en, 1'b0});
`ifdef RISCV_IRQ_PRIORITY_EN
            OFF_THRESH:  w_rword = 32'(r_thresh);
`else
            OFF_THRESH:  w_rword = '0;
`endif
            OFF_CLAIM:   w_rword = 32'(w_best);
            default: begin
`ifdef RISCV_IRQ_PRIORITY_EN
                for (int i = 1; i <= N_SRC; i++) begin
                    if (w_req.off >= OFF_PRIO_BASE && w_slot == 6'(i)) begin
                        w_rword = 32'(r_prio[i]);
                    end
                end
`else
                w_rword = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            irq_out    <= 1'b0;
        end else begin
            bus_rvalid <= w_req.rd;
            irq_out    <= |w_elig;
            if (w_req.rd) begin
                bus_rdata <= w_rword;
            end
        end
    end

endmodule

// File: tb/tb_riscv_irq_controller.sv
// Randomised scoreboard bench for riscv_irq_controller against a
// behavioural model of pending/in-service/enable state per source.
module tb_riscv_irq_controller;

    localparam int          N     = 8;
    localparam logic [N-1:0] EMASK = 8'h01;
    localparam logic [31:0] BASE  = 32'h0000c000;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src_irq;
    logic [31:0]   bus_addr;
    logic          bus_re;
    logic          bus_we;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_rvalid;
    logic          irq_out;

    always #5 clk = ~clk;

    riscv_irq_controller #(
        .N_SRC     (N),
        .EDGE_MASK (EMASK),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .bus_addr   (bus_addr),
        .bus_re     (bus_re),
        .bus_we     (bus_we),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .irq_out    (irq_out)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];

    bit m_pend [0:31];
    bit m_svc  [0:31];
    bit m_en   [0:31];
    bit m_line [0:31];
    int m_prio [0:31];
    int m_thresh;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit elig(int i);
        bit e;
        e = m_pend[i] && m_en[i] && !m_svc[i];
`ifdef RISCV_IRQ_PRIORITY_EN
        e = e && (m_prio[i] > m_thresh);
`endif
        return e;
    endfunction

    function automatic int best_id();
        int b  = 0;
        int bp = -1;
        for (int i = 1; i <= N; i++) begin
            if (elig(i)) begin
                int p = 0;
`ifdef RISCV_IRQ_PRIORITY_EN
                p = m_prio[i];
`endif
                if (p > bp) begin
                    b  = i;
                    bp = p;
                end
            end
        end
        return b;
    endfunction

    function automatic bit any_elig();
        bit a = 0;
        for (int i = 1; i <= N; i++) a = a | elig(i);
        return a;
    endfunction

    function automatic logic [31:0] exp_word(logic [7:0] off);
        logic [31:0] w = '0;
        if (off == 8'h00) begin
            for (int i = 1; i <= N; i++) w[i] = m_pend[i];
        end else if (off == 8'h04) begin
            for (int i = 1; i <= N; i++) w[i] = m_en[i];
        end
`ifdef RISCV_IRQ_PRIORITY_EN
        else if (off == 8'h08) begin
            w = 32'(m_thresh);
        end else if (off >= 8'h24 && off <= 8'h20 + 8'(4 * N)) begin
            w = 32'(m_prio[(off - 8'h20) / 4]);
        end
`endif
        return w;
    endfunction

    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (!rst && bus_rvalid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got rvalid data %h expected none",
                         bus_rdata);
            end else begin
                e = sb_q.pop_front();
                chk("sb_read", bus_rdata, e);
            end
        end
    end

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [31:0] addr);
        @(negedge clk);
        bus_addr = addr;
        bus_re   = 1'b1;
        @(negedge clk);
        bus_re   = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        bus_addr  = addr;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic op_read(input logic [7:0] off);
        sb_q.push_back(exp_word(off));
        bus_rd(BASE + 32'(off));
    endtask

    task automatic claim_model();
        int b = best_id();
        sb_q.push_back(32'(b));
        if (b != 0) begin
            m_svc[b]  = 1;
            m_pend[b] = !EMASK[b-1] && m_line[b];
        end
    endtask

    task automatic op_claim();
        claim_model();
        bus_rd(BASE + 32'h0C);
    endtask

    task automatic op_complete(input int id);
        if (id >= 1 && id <= N && m_svc[id]) begin
            m_svc[id] = 0;
            if (!EMASK[id-1] && m_line[id]) m_pend[id] = 1;
        end
        bus_wr(BASE + 32'h0C, 32'(id));
    endtask

    task automatic op_en(input logic [31:0] v);
        for (int i = 1; i <= N; i++) m_en[i] = v[i];
        bus_wr(BASE + 32'h04, v);
    endtask

    task automatic op_line(input int id, input bit v);
        @(negedge clk);
        src_irq[id-1] = v;
        m_line[id]    = v;
        if (v && !m_svc[id]) m_pend[id] = 1;
        settle();
    endtask

    task automatic op_pulse();
        @(negedge clk);
        src_irq[0] = 1'b1;
        repeat (3) @(negedge clk);
        src_irq[0] = 1'b0;
        m_pend[1]  = 1;
        settle();
    endtask

    task automatic op_thresh(input int v);
`ifdef RISCV_IRQ_PRIORITY_EN
        m_thresh = v;
`endif
        bus_wr(BASE + 32'h08, 32'(v));
    endtask

    task automatic op_prio(input int id, input int v);
`ifdef RISCV_IRQ_PRIORITY_EN
        m_prio[id] = v;
`endif
        bus_wr(BASE + 32'h20 + 32'(4 * id), 32'(v));
    endtask

    task automatic chk_irq(input string nm);
        chk(nm, 32'(irq_out), 32'(any_elig()));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0;
            m_svc[i]  = 0;
            m_en[i]   = 0;
            m_line[i] = 0;
            m_prio[i] = 0;
        end
        m_thresh = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        model_clear();
        rst       = 1'b1;
        src_irq   = '0;
        bus_addr  = '0;
        bus_re    = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        @(posedge clk);
        #1;
        chk("reset_rdata", bus_rdata, 32'h0);
        chk("reset_rvalid", 32'(bus_rvalid), 32'h0);
        chk("reset_irq", 32'(irq_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        op_read(8'h00);
        op_read(8'h04);

`ifdef RISCV_IRQ_PRIORITY_EN
        for (int i = 1; i <= N; i++) op_prio(i, 1);
`endif

        // Level ID 3: exact latency, claim, complete while high
        op_en(32'h08);
        settle();
        @(negedge clk);
        src_irq[2] = 1'b1;
        m_line[3]  = 1;
        m_pend[3]  = 1;
        repeat (3) @(posedge clk);
        #1 chk("t1_irq_c3", 32'(irq_out), 32'h0);
        @(posedge clk);
        #1 chk("t1_irq_c4", 32'(irq_out), 32'h1);
        claim_model();
        @(negedge clk);
        bus_addr = BASE + 32'h0C;
        bus_re   = 1'b1;
        @(posedge clk);
        #1 chk("t1_irq_claim_edge", 32'(irq_out), 32'h1);
        @(negedge clk);
        bus_re = 1'b0;
        @(posedge clk);
        #1 chk("t1_irq_after_claim", 32'(irq_out), 32'h0);
        settle();
        op_complete(3);
        settle();
        chk("t1_irq_after_complete", 32'(irq_out), 32'h1);
        op_line(3, 0);

        // IDs 2 and 5: lowest ID first, then none
        op_en(32'h24);
        op_line(2, 1);
        op_line(5, 1);
        op_claim();
        op_claim();
        op_claim();
        settle();
        chk_irq("t2_irq");
        op_line(2, 0);
        op_line(5, 0);
        op_complete(2);
        op_complete(5);
        settle();

        // Priority / threshold
        op_line(2, 1);
        op_line(5, 1);
        op_prio(2, 1);
        op_prio(5, 4);
        op_thresh(3);
        op_read(8'h08);
        op_read(8'h28);
        op_claim();
        settle();
        chk_irq("t3_irq_thresh");
        op_complete(5);
        op_thresh(0);
        op_claim();
        settle();
        op_line(2, 0);
        op_line(5, 0);
        op_complete(2);
        op_complete(5);
        settle();
        b = best_id();
        while (b != 0) begin
            op_claim();
            op_complete(b);
            b = best_id();
        end
        settle();

        // Edge ID 1: one-deep capture while in service, loss while pending
        op_en(32'h02);
        op_pulse();
        op_claim();
        op_pulse();
        op_read(8'h00);
        op_complete(1);
        settle();
        chk_irq("t4_irq_repend");
        op_pulse();
        op_claim();
        op_claim();
        op_complete(1);
        settle();

        // Ignored completes, disabled pending source, write-only strobe
        op_complete(7);
        op_complete(0);
        op_read(8'h00);
        op_line(4, 1);
        op_read(8'h00);
        chk_irq("t5_irq_disabled");
        @(negedge clk);
        bus_addr  = BASE + 32'h04;
        bus_wdata = 32'h1FE;
        bus_re    = 1'b1;
        bus_we    = 1'b1;
        for (int i = 1; i <= N; i++) m_en[i] = 1;
        @(negedge clk);
        bus_re = 1'b0;
        bus_we = 1'b0;
        op_read(8'h04);
        bus_rd(BASE + 32'h100);
        op_read(8'h10);
        settle();

        // Reset while a claim is in service
        b = best_id();
        op_claim();
        settle();
        @(negedge clk);
        rst     = 1'b1;
        src_irq = '0;
        model_clear();
        @(posedge clk);
        #1;
        chk("t6_rdata", bus_rdata, 32'h0);
        chk("t6_rvalid", 32'(bus_rvalid), 32'h0);
        chk("t6_irq", 32'(irq_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        settle();
`ifdef RISCV_IRQ_PRIORITY_EN
        for (int i = 1; i <= N; i++) op_prio(i, 1);
`endif
        op_en(32'h40);
        op_line(6, 1);
        chk_irq("t6_irq_fresh");
        op_claim();
        op_line(6, 0);
        op_complete(6);
        settle();

        // Random mix
`ifdef RISCV_IRQ_PRIORITY_EN
        for (int i = 1; i <= N; i++) op_prio(i, int'($urandom_range(1, 7)));
        op_thresh(int'($urandom_range(0, 2)));
`endif
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0: op_line(int'($urandom_range(2, N)), 1'($urandom_range(0, 1)));
                1: op_pulse();
                2: op_en($urandom);
                3, 4: op_claim();
                5: begin
                    int id = int'($urandom_range(0, 10));
                    if ($urandom_range(0, 1) == 1) begin
                        for (int i = 1; i <= N; i++) if (m_svc[i]) id = i;
                    end
                    op_complete(id);
                end
                6: op_read(8'h00);
                default: begin
                    case ($urandom_range(0, 4))
                        0: op_read(8'h04);
                        1: op_read(8'h08);
                        2: op_read(8'h24);
                        3: op_read(8'hFC);
                        default: bus_rd(BASE + 32'h200);
                    endcase
                end
            endcase
            settle();
            chk_irq("rand_irq");
        end

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
